// File: rtl/alu_mdu.sv
// alu_mdu: registered W-bit execute-stage ALU with an iterative multiply/divide
// unit and architectural HI/LO registers.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   valid_i      operation request, accepted when busy_o is low
//   funct_i6     MIPS R-type funct (decoded only when alt_ctrl_i2 == 2'b00)
//   alt_ctrl_i2  00 funct decode, 01 ADD, 10 SUB, 11 SLT
//   a_i, b_i     operands; shift amount is b_i[$clog2(W)-1:0]
//   busy_o       MDU iterating; requests are dropped while high
//   valid_o      one-cycle result strobe
//   y_o          registered result
//   zero_o       registered (y_o == 0)
//   hi_o, lo_o   HI/LO contents
//   ovf_o        signed overflow on ADD/SUB (only with ALU_OVF_EN)
//
// Optional feature: define ALU_OVF_EN to add the ovf_o output.
//
// Single-cycle ops register y_o at the accept edge. MULT/MULTU/DIV/DIVU take
// W CALC edges (radix-2 shift-add / restoring divide on magnitudes) plus one
// FIX edge that applies the sign correction and writes HI/LO.

module alu_mdu #(
  parameter int W     = 32,
  parameter int CNT_W = $clog2(W) + 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  input  logic [5:0]   funct_i6,
  input  logic [1:0]   alt_ctrl_i2,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         busy_o,
  output logic         valid_o,
  output logic [W-1:0] y_o,
  output logic         zero_o,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o
`ifdef ALU_OVF_EN
  ,
  output logic         ovf_o
`endif
);

  localparam int SH_W = $clog2(W);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t state, state_nxt;

  // Two's-complement negate when neg is set.
  function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic neg);
    return neg ? (~v + W'(1)) : v;
  endfunction

  logic signed [W-1:0] a_s, b_s;
  logic [W-1:0]        sum, diff;
  logic [SH_W-1:0]     sh;

  assign a_s  = a_i;
  assign b_s  = b_i;
  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;
  assign sh   = b_i[SH_W-1:0];

  logic         accept;
  logic         is_mdu, mdu_mul, mdu_sgn;
  logic         wr_hi, wr_lo;
  logic [W-1:0] alu_y;
`ifdef ALU_OVF_EN
  logic         add_ovf, sub_ovf, alu_ovf;
  assign add_ovf = (a_i[W-1] == b_i[W-1]) && (sum[W-1]  != a_i[W-1]);
  assign sub_ovf = (a_i[W-1] != b_i[W-1]) && (diff[W-1] != a_i[W-1]);
`endif

  assign busy_o = (state != S_IDLE);
  assign accept = valid_i && (state == S_IDLE);

  always_comb begin
    alu_y   = '0;
    is_mdu  = 1'b0;
    mdu_mul = 1'b0;
    mdu_sgn = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
`ifdef ALU_OVF_EN
    alu_ovf = 1'b0;
`endif
    case (alt_ctrl_i2)
      2'b01: begin
        alu_y = sum;
`ifdef ALU_OVF_EN
        alu_ovf = add_ovf;
`endif
      end
      2'b10: begin
        alu_y = diff;
`ifdef ALU_OVF_EN
        alu_ovf = sub_ovf;
`endif
      end
      2'b11: alu_y = {{(W-1){1'b0}}, (a_s < b_s)};
      default: begin
        case (funct_i6)
          6'h20: begin
            alu_y = sum;
`ifdef ALU_OVF_EN
            alu_ovf = add_ovf;
`endif
          end
          6'h21: alu_y = sum;
          6'h22: begin
            alu_y = diff;
`ifdef ALU_OVF_EN
            alu_ovf = sub_ovf;
`endif
          end
          6'h23: alu_y = diff;
          6'h24: alu_y = a_i & b_i;
          6'h25: alu_y = a_i | b_i;
          6'h26: alu_y = a_i ^ b_i;
          6'h27: alu_y = ~(a_i | b_i);
          6'h2A: alu_y = {{(W-1){1'b0}}, (a_s < b_s)};
          6'h2B: alu_y = {{(W-1){1'b0}}, (a_i < b_i)};
          6'h00: alu_y = a_i << sh;
          6'h02: alu_y = a_i >> sh;
          6'h03: alu_y = a_s >>> sh;
          6'h10: alu_y = hi_o;
          6'h12: alu_y = lo_o;
          6'h11: begin
            alu_y = a_i;
            wr_hi = 1'b1;
          end
          6'h13: begin
            alu_y = a_i;
            wr_lo = 1'b1;
          end
          6'h18: begin
            is_mdu  = 1'b1;
            mdu_mul = 1'b1;
            mdu_sgn = 1'b1;
          end
          6'h19: begin
            is_mdu  = 1'b1;
            mdu_mul = 1'b1;
          end
          6'h1A: begin
            is_mdu  = 1'b1;
            mdu_sgn = 1'b1;
          end
          6'h1B: is_mdu = 1'b1;
          default: alu_y = '0;
        endcase
      end
    endcase
  end

  // MDU working registers: acc_hi/acc_lo hold the 2W product (multiply) or
  // remainder/quotient (divide); opd is the multiplicand or divisor magnitude.
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     acc_hi, acc_lo, opd;
  logic             op_mul, neg_lo, neg_hi;
  logic             a_neg, b_neg;

  assign a_neg = mdu_sgn & a_i[W-1];
  assign b_neg = mdu_sgn & b_i[W-1];

  logic [W:0]     mul_sum, rem_sh, div_try;
  logic [2*W-1:0] prod_raw, prod_fix;
  logic [W-1:0]   fix_hi, fix_lo;

  assign mul_sum  = {1'b0, acc_hi} + {1'b0, opd};
  assign rem_sh   = {acc_hi, acc_lo[W-1]};
  assign div_try  = rem_sh - {1'b0, opd};
  assign prod_raw = {acc_hi, acc_lo};
  assign prod_fix = neg_lo ? (~prod_raw + (2*W)'(1)) : prod_raw;
  assign fix_hi   = op_mul ? prod_fix[2*W-1:W] : cond_neg(acc_hi, neg_hi);
  assign fix_lo   = op_mul ? prod_fix[W-1:0]   : cond_neg(acc_lo, neg_lo);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept && is_mdu) state_nxt = S_CALC;
      S_CALC: if (cnt == CNT_W'(W - 1)) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control and architectural state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      cnt     <= '0;
      valid_o <= 1'b0;
      y_o     <= '0;
      zero_o  <= 1'b1;
      hi_o    <= '0;
      lo_o    <= '0;
`ifdef ALU_OVF_EN
      ovf_o   <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      valid_o <= 1'b0;
`ifdef ALU_OVF_EN
      ovf_o   <= 1'b0;
`endif
      if (accept && !is_mdu) begin
        y_o     <= alu_y;
        zero_o  <= (alu_y == '0);
        valid_o <= 1'b1;
`ifdef ALU_OVF_EN
        ovf_o   <= alu_ovf;
`endif
        if (wr_hi) hi_o <= a_i;
        if (wr_lo) lo_o <= a_i;
      end
      if (accept && is_mdu) cnt <= '0;
      else if (state == S_CALC) cnt <= cnt + CNT_W'(1);
      if (state == S_FIX) begin
        hi_o    <= fix_hi;
        lo_o    <= fix_lo;
        y_o     <= fix_lo;
        zero_o  <= (fix_lo == '0);
        valid_o <= 1'b1;
      end
    end
  end

  // MDU datapath (no reset: contents are only consumed after an accept)
  always_ff @(posedge clk_i) begin
    if (accept && is_mdu) begin
      op_mul <= mdu_mul;
      acc_hi <= '0;
      if (mdu_mul) begin
        acc_lo <= cond_neg(b_i, b_neg);
        opd    <= cond_neg(a_i, a_neg);
        neg_lo <= a_neg ^ b_neg;
        neg_hi <= a_neg ^ b_neg;
      end else begin
        acc_lo <= cond_neg(a_i, a_neg);
        opd    <= cond_neg(b_i, b_neg);
        // Divide by zero yields an all-ones quotient; keeping it unnegated
        // leaves LO = all ones, while HI rebuilds the raw dividend.
        neg_lo <= (a_neg ^ b_neg) && (b_i != '0);
        neg_hi <= a_neg;
      end
    end else if (state == S_CALC) begin
      if (op_mul) begin
        if (acc_lo[0]) {acc_hi, acc_lo} <= {mul_sum, acc_lo[W-1:1]};
        else           {acc_hi, acc_lo} <= {1'b0, acc_hi, acc_lo[W-1:1]};
      end else begin
        if (div_try[W]) begin
          acc_hi <= rem_sh[W-1:0];
          acc_lo <= {acc_lo[W-2:0], 1'b0};
        end else begin
          acc_hi <= div_try[W-1:0];
          acc_lo <= {acc_lo[W-2:0], 1'b1};
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
module tb_alu_mdu;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic [5:0]  funct_i6 = '0;
  logic [1:0]  alt_ctrl_i2 = '0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        busy_o, valid_o, zero_o;
  logic [31:0] y_o, hi_o, lo_o;
`ifdef ALU_OVF_EN
  logic        ovf_o;
`endif

  alu_mdu #(.W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .funct_i6(funct_i6),
    .alt_ctrl_i2(alt_ctrl_i2), .a_i(a_i), .b_i(b_i), .busy_o(busy_o),
    .valid_o(valid_o), .y_o(y_o), .zero_o(zero_o), .hi_o(hi_o), .lo_o(lo_o)
`ifdef ALU_OVF_EN
    , .ovf_o(ovf_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] y;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        ovf;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // Monitor: pops one expectation per result strobe.
  always @(negedge clk_i) begin
    if (!rst_i && valid_o) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid got=1 want=0 y=%h", y_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.nm, ".y"}, y_o, e.y);
        chk({e.nm, ".zero"}, {31'b0, zero_o}, {31'b0, (e.y == 32'h0)});
        chk({e.nm, ".hi"}, hi_o, e.hi);
        chk({e.nm, ".lo"}, lo_o, e.lo);
`ifdef ALU_OVF_EN
        chk({e.nm, ".ovf"}, {31'b0, ovf_o}, {31'b0, e.ovf});
`endif
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the accept edge.
  task automatic issue(input logic [5:0] f, input logic [1:0] alt,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ey, input logic [31:0] ehi,
                       input logic [31:0] elo, input logic eovf,
                       input bit push, input string nm);
    int n;
    exp_t e;
    n = 0;
    while (busy_o && n < 200) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (busy_o) chk({nm, ".wait_idle"}, 32'd1, 32'd0);
    funct_i6 = f; alt_ctrl_i2 = alt; a_i = a; b_i = b; valid_i = 1'b1;
    if (push) begin
      e.y = ey; e.hi = ehi; e.lo = elo; e.ovf = eovf; e.nm = nm;
      sb.push_back(e);
    end
    @(posedge clk_i); #1;
    valid_i = 1'b0;
  endtask

  initial begin
    int n;
    int busy_cnt;
    bit held;

    repeat (3) @(posedge clk_i);
    #1;
    chk("rst.busy", {31'b0, busy_o}, 32'd0);
    chk("rst.valid", {31'b0, valid_o}, 32'd0);
    chk("rst.y", y_o, 32'h0);
    chk("rst.zero", {31'b0, zero_o}, 32'd1);
    chk("rst.hi", hi_o, 32'h0);
    chk("rst.lo", lo_o, 32'h0);
    rst_i = 1'b0;

    // Single-cycle ops, HI=LO=0 until MTHI/MTLO
    issue(6'h20, 2'b00, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, 1'b1, 1, "add_ovf");
    issue(6'h21, 2'b00, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, 1'b0, 1, "addu");
    issue(6'h22, 2'b00, 32'h5, 32'h5, 32'h0, 0, 0, 1'b0, 1, "sub_zero");
    issue(6'h22, 2'b00, 32'h80000000, 32'h1, 32'h7FFFFFFF, 0, 0, 1'b1, 1, "sub_ovf");
    issue(6'h23, 2'b00, 32'h0, 32'h1, 32'hFFFFFFFF, 0, 0, 1'b0, 1, "subu");
    issue(6'h24, 2'b00, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 0, 0, 1'b0, 1, "and");
    issue(6'h25, 2'b00, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 0, 0, 1'b0, 1, "or");
    issue(6'h26, 2'b00, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 0, 0, 1'b0, 1, "xor");
    issue(6'h27, 2'b00, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 0, 1'b0, 1, "nor");
    issue(6'h2A, 2'b00, 32'hFFFFFFFF, 32'h1, 32'h1, 0, 0, 1'b0, 1, "slt");
    issue(6'h2B, 2'b00, 32'hFFFFFFFF, 32'h1, 32'h0, 0, 0, 1'b0, 1, "sltu");
    issue(6'h00, 2'b00, 32'h1, 32'd31, 32'h80000000, 0, 0, 1'b0, 1, "sll31");
    issue(6'h00, 2'b00, 32'h1, 32'h21, 32'h2, 0, 0, 1'b0, 1, "sll_mask");
    issue(6'h02, 2'b00, 32'h80000000, 32'd4, 32'h08000000, 0, 0, 1'b0, 1, "srl");
    issue(6'h03, 2'b00, 32'h80000000, 32'd4, 32'hF8000000, 0, 0, 1'b0, 1, "sra");
    issue(6'h3F, 2'b01, 32'h3, 32'h4, 32'h7, 0, 0, 1'b0, 1, "alt_add");
    issue(6'h3F, 2'b01, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, 1'b1, 1, "alt_add_ovf");
    issue(6'h3F, 2'b10, 32'h3, 32'h4, 32'hFFFFFFFF, 0, 0, 1'b0, 1, "alt_sub");
    issue(6'h3F, 2'b10, 32'h80000000, 32'h1, 32'h7FFFFFFF, 0, 0, 1'b1, 1, "alt_sub_ovf");
    issue(6'h3F, 2'b11, 32'h80000000, 32'h0, 32'h1, 0, 0, 1'b0, 1, "alt_slt");
    issue(6'h3F, 2'b00, 32'h1234, 32'h1, 32'h0, 0, 0, 1'b0, 1, "undef");
    issue(6'h11, 2'b00, 32'h12345678, 32'h0, 32'h12345678, 32'h12345678, 0, 1'b0, 1, "mthi");
    issue(6'h13, 2'b00, 32'h9ABCDEF0, 32'h0, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1, "mtlo");
    issue(6'h10, 2'b00, 32'h0, 32'h0, 32'h12345678, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1, "mfhi");
    issue(6'h12, 2'b00, 32'h0, 32'h0, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1, "mflo");

    // MULT: busy duration and result latency
    issue(6'h18, 2'b00, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1, "mult");
    n = 0;
    busy_cnt = busy_o ? 1 : 0;
    while (!valid_o && n < 100) begin
      @(posedge clk_i); #1;
      n++;
      if (busy_o) busy_cnt++;
    end
    chk("mult.latency", n, 32'd33);
    chk("mult.busy_cycles", busy_cnt, 32'd33);

    // Back-to-back with the strobe cycle
    issue(6'h10, 2'b00, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1, "mfhi_mult");
    issue(6'h12, 2'b00, 32'h0, 32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1, "mflo_mult");
    issue(6'h19, 2'b00, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFE, 1'b0, 1, "multu");
    issue(6'h1A, 2'b00, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1, "div_neg");
    issue(6'h1B, 2'b00, 32'h7, 32'h0, 32'hFFFFFFFF, 32'h7, 32'hFFFFFFFF, 1'b0, 1, "divu_by0");
    issue(6'h1A, 2'b00, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0, 1, "div_by0");
    issue(6'h1A, 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 32'h80000000, 1'b0, 1, "div_min");
    issue(6'h1B, 2'b00, 32'd100, 32'd7, 32'd14, 32'd2, 32'd14, 1'b0, 1, "divu");
    issue(6'h1A, 2'b00, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1, 32'hFFFFFFFD, 1'b0, 1, "div_pos_neg");

    // Requests during MULT are dropped; state holds until the result
    issue(6'h18, 2'b00, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1, "mult_drop");
    held = 1'b1;
    n = 0;
    while (busy_o && n < 100) begin
      funct_i6 = 6'h20; alt_ctrl_i2 = 2'b00; a_i = 32'h1; b_i = 32'h1; valid_i = 1'b1;
      if (y_o !== 32'hFFFFFFFD || hi_o !== 32'h1 || lo_o !== 32'hFFFFFFFD) held = 1'b0;
      @(posedge clk_i); #1;
      n++;
    end
    valid_i = 1'b0;
    chk("drop.hold", {31'b0, held}, 32'd1);
    issue(6'h10, 2'b00, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1, "mfhi_drop");
    issue(6'h12, 2'b00, 32'h0, 32'h0, 32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1, "mflo_drop");

    // Reset mid-CALC aborts without a result
    issue(6'h18, 2'b00, 32'h1234, 32'h5678, 32'h0, 32'h0, 32'h0, 1'b0, 0, "mult_abort");
    repeat (9) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk("abort.busy", {31'b0, busy_o}, 32'd0);
    chk("abort.valid", {31'b0, valid_o}, 32'd0);
    chk("abort.hi", hi_o, 32'h0);
    chk("abort.lo", lo_o, 32'h0);
    issue(6'h19, 2'b00, 32'd3, 32'd5, 32'd15, 32'd0, 32'd15, 1'b0, 1, "multu_after_rst");

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk_i); #1;
      n++;
    end
    repeat (2) @(posedge clk_i);
    #1;
    chk("sb.drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
